qam_frame_sequencer: RTL and testbench
======================================

// Module: qam_frame_sequencer
// PURPOSE
//  Sequences the 16-QAM modulator: derives bit-rate and symbol-rate strobes from clk, pulls a serial
//  bit stream via handshake, packs 4 bits per symbol, prefixes each frame with preamble symbols,
//  and hands {I,Q} symbols to the level mapper with valid/ready and a frame-alignment flag.
//  Sits between the bit source (PRBS/payload) and the I/Q mapper driving Siga/Sigb.
// PARAMETERS
//  BIT_DIV        8   clk cycles per bit slot (>=2)
//  PREAMBLE_SYMS  4   preamble symbols per frame (1..255)
//  FRAME_SYMS     16  data symbols per frame (1..255)
// PORTS
//  clk           in   1  system clock, all state on rising edge
//  rst           in   1  reset, asynchronous, active-low (0 = reset)
//  enable        in   1  1 = run frames back-to-back; sampled only in IDLE and at frame end
//  bit_in        in   1  serial payload bit
//  bit_valid     in   1  bit_in holds a valid bit
//  bit_ready     out  1  bit_in consumed this cycle (one-cycle pulse)
//  sym_out       out  4  symbol {I[1:0],Q[1:0]} = sym_out[3:2], sym_out[1:0]; first bit -> bit 3
//  sym_valid     out  1  sym_out valid; held until sym_ready
//  sym_ready     in   1  mapper accepts sym_out when sym_valid&&sym_ready
//  m_align       out  1  qualifies sym_out as first data symbol of a frame; changes only with sym_out
//  clk_m         out  1  bit-rate strobe, one-cycle pulse
//  clk_level     out  1  symbol-rate strobe, one-cycle pulse, high in the cycle a new sym_out appears
//  frame_busy    out  1  state != IDLE
//  underrun_cnt  out  8  bit slots with bit_valid=0 in DATA; saturates at 255
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, divider/bit/symbol counters 0, underrun_cnt 0.
//  - FSM: IDLE -> PREAMBLE when enable=1 (divider cleared on entry). PREAMBLE -> DATA after
//    PREAMBLE_SYMS symbols loaded. DATA -> PREAMBLE after FRAME_SYMS symbols loaded if enable=1,
//    else -> IDLE. enable=0 mid-frame has no effect until frame end.
//  - Divider div counts 0..BIT_DIV-1 in PREAMBLE/DATA, held at 0 in IDLE.
//    stall = (bit_cnt==3) && sym_valid && !sym_ready; clk_m = (div==BIT_DIV-1) && !stall;
//    div holds at BIT_DIV-1 while stall. First clk_m is BIT_DIV cycles after entering PREAMBLE.
//  - Each clk_m advances 2-bit bit_cnt. DATA: bit_ready = clk_m; bit shifted in (MSB first);
//    if bit_valid=0 the slot is filled with 0 and underrun_cnt increments (saturating).
//    PREAMBLE: no bits consumed, bit_ready=0.
//  - On the clk_m with bit_cnt==3: sym_out loads (packed bits, or preamble pattern 4'b0011 on even,
//    4'b1100 on odd preamble index), sym_valid<=1, clk_level<=1 next cycle only,
//    m_align<=1 iff first DATA symbol of frame, else 0. Load at a cycle with sym_valid&&sym_ready
//    is legal (slot freed same edge).
//  - sym_valid&&sym_ready with no load that edge: sym_valid<=0; sym_out, m_align hold.
//  - Backpressure never drops or duplicates bits: divider freezes, clk_m/bit_ready stay low.
//  - Last DATA symbol load and next PREAMBLE start share the edge; divider and bit_cnt continue
//    seamlessly (no gap) when enable=1. Entering IDLE: sym_valid stays until accepted.
//  - Async reset mid-operation: immediate clear; pending symbol discarded.
//  - Symbol counter 8 bits, compared against PREAMBLE_SYMS-1 / FRAME_SYMS-1, cleared per phase.
// TESTING
//  1 rst=0 with random inputs -> every output 0, frame_busy=0; release -> stays IDLE while enable=0.
//  2 enable=1, sym_ready=1, bit_valid=1 bits 1,0,1,1,... -> clk_m every 8 cycles; first sym_valid
//    after 32 cycles; preamble 3,C,3,C; 5th symbol 4'hB with m_align=1; others m_align=0.
//  3 sym_ready=0 for 100 cycles after a symbol -> exactly 3 more clk_m then none, sym_out stable;
//    sym_ready=1 -> one clk_m, next symbol loads, no bit lost (compare against source model).
//  4 bit_valid=0 for 2 DATA slots -> zeros packed, underrun_cnt=2; hold low 300 slots -> 255.
//  5 enable=0 at 3rd data symbol -> frame completes all 16 data symbols, then IDLE, frame_busy=0,
//    clk_m stops; enable kept 1 -> 2nd frame preamble follows with no idle cycles.
//  6 rst pulse low mid-DATA -> outputs 0 same cycle; after release new frame starts with preamble.

Source files
------------

// File: rtl/qam_frame_sequencer.sv
// qam_frame_sequencer: 16-QAM framing, bit/symbol strobes, 4-bit packing and preamble insertion
module qam_frame_sequencer #(
   parameter int BIT_DIV       = 8,
   parameter int PREAMBLE_SYMS = 4,
   parameter int FRAME_SYMS    = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       bit_in,
   input  logic       bit_valid,
   output logic       bit_ready,
   output logic [3:0] sym_out,
   output logic       sym_valid,
   input  logic       sym_ready,
   output logic       m_align,
   output logic       clk_m,
   output logic       clk_level,
   output logic       frame_busy,
   output logic [7:0] underrun_cnt
);
   localparam int DW = $clog2(BIT_DIV);
   localparam logic [DW-1:0] DIV_MAX = DW'(BIT_DIV - 1);
   localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_SYMS - 1);
   localparam logic [7:0] DATA_LAST = 8'(FRAME_SYMS - 1);

   typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;
   state_t state, state_nxt;
   logic [DW-1:0] div;
   logic [1:0] bit_cnt;
   logic [7:0] sym_cnt;
   logic [2:0] shreg;
   logic stall, load, last;

   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_nxt;

   always_comb
      state_nxt = state == IDLE ? (enable ? PREAMBLE : IDLE) :
                  !(load && last) ? state :
                  state == PREAMBLE ? DATA :
                  enable ? PREAMBLE : IDLE;

   // a held symbol freezes the divider only once the next symbol is complete
   always_comb begin
      frame_busy = state != IDLE;
      stall = bit_cnt == 2'd3 && sym_valid && !sym_ready;
      clk_m = frame_busy && div == DIV_MAX && !stall;
      bit_ready = clk_m && state == DATA;
      load = clk_m && bit_cnt == 2'd3;
      last = state == DATA ? sym_cnt == DATA_LAST : sym_cnt == PRE_LAST;
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         div <= '0;
         bit_cnt <= '0;
         sym_cnt <= '0;
         shreg <= '0;
         sym_out <= '0;
         sym_valid <= 1'b0;
         m_align <= 1'b0;
         clk_level <= 1'b0;
         underrun_cnt <= '0;
      end else begin
         div <= state == IDLE ? '0 : div != DIV_MAX ? div + 1'b1 : stall ? div : '0;
         if (clk_m) bit_cnt <= bit_cnt + 2'd1;
         if (bit_ready) shreg <= {shreg[1:0], bit_valid & bit_in};
         if (bit_ready && !bit_valid && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
         if (load) begin
            sym_out <= state == DATA ? {shreg, bit_valid & bit_in} : (sym_cnt[0] ? 4'hC : 4'h3);
            m_align <= state == DATA && sym_cnt == 8'd0;
            sym_cnt <= last ? 8'd0 : sym_cnt + 8'd1;
         end
         sym_valid <= load || (sym_valid && !sym_ready);
         clk_level <= load;
      end
endmodule

// File: tb/tb_qam_frame_sequencer.sv
// tb_qam_frame_sequencer: directed table plus multi-cycle sequences against a bit-source reference
module tb_qam_frame_sequencer;
   logic clk = 0, rst = 0, enable = 0, bit_valid = 0, sym_ready = 0;
   logic bit_in, bit_ready, sym_valid, m_align, clk_m, clk_level, frame_busy;
   logic [3:0] sym_out;
   logic [7:0] underrun_cnt;
   int checks = 0, failures = 0, cyc = 0, m_cnt = 0, src_idx = 0;
   logic src [0:511];
   logic [4:0] acc_q[$];
   int lvl_q[$];

   typedef struct packed {logic [3:0] bits; logic [3:0] sym; logic align;} vec_t;
   vec_t tbl [20];
   logic [3:0] dbits [16];

   qam_frame_sequencer dut (
      .clk(clk), .rst(rst), .enable(enable), .bit_in(bit_in), .bit_valid(bit_valid),
      .bit_ready(bit_ready), .sym_out(sym_out), .sym_valid(sym_valid), .sym_ready(sym_ready),
      .m_align(m_align), .clk_m(clk_m), .clk_level(clk_level), .frame_busy(frame_busy),
      .underrun_cnt(underrun_cnt)
   );

   always #5 clk = ~clk;
   assign bit_in = src[src_idx[8:0]];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (clk_m) m_cnt <= m_cnt + 1;
      if (!rst) src_idx <= 0;
      else if (bit_ready && bit_valid) src_idx <= src_idx + 1;
      if (sym_valid && sym_ready) acc_q.push_back({m_align, sym_out});
      if (clk_level) lvl_q.push_back(cyc);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_acc(input int n, input int budget);
      int k = 0;
      while (acc_q.size() < n && k < budget) begin
         tick;
         k++;
      end
      if (acc_q.size() < n) chk("acc_timeout", acc_q.size(), n);
   endtask

   // expected symbol s of an uninterrupted run: 4 preamble then 16 data per frame
   function automatic logic [4:0] exp_a(input int s);
      int p, d;
      p = s % 20;
      d = (s / 20) * 16 + p - 4;
      if (p < 4) return {1'b0, (p % 2 == 1) ? 4'hC : 4'h3};
      return {p == 4, src[4*d], src[4*d+1], src[4*d+2], src[4*d+3]};
   endfunction

   function automatic logic [17:0] outs;
      return {bit_ready, sym_out, sym_valid, m_align, clk_m, clk_level, frame_busy, underrun_cnt};
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, k, first_m, m0;
      logic [3:0] held;
      logic stable;
      dbits = '{4'hB, 4'h5, 4'hE, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4,
                4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hC, 4'hD, 4'h0};
      for (int i = 0; i < 20; i++)
         tbl[i] = i < 4 ? '{4'h0, (i % 2 == 1) ? 4'hC : 4'h3, 1'b0}
                        : '{dbits[i-4], dbits[i-4], 1'(i == 4)};
      for (int i = 0; i < 512; i++)
         src[i] = i < 64 ? tbl[4 + i/4].bits[3 - i%4] : 1'(((i * 7) / 3) % 2);

      // held in reset with random inputs
      for (int i = 0; i < 8; i++) begin
         enable = 1'($urandom);
         bit_valid = 1'($urandom);
         sym_ready = 1'($urandom);
         #1;
         chk("reset_outs", outs(), 0);
         tick;
      end
      enable = 0;
      bit_valid = 1;
      sym_ready = 1;
      rst = 1;
      m0 = m_cnt;
      repeat (20) tick;
      chk("idle_busy", frame_busy, 0);
      chk("idle_clk_m", m_cnt - m0, 0);

      // first frame: strobe timing then table of symbols
      enable = 1;
      n = 0;
      first_m = 0;
      while (!sym_valid && n < 100) begin
         tick;
         n++;
         if (clk_m && first_m == 0) first_m = n;
      end
      chk("first_clk_m", first_m, 8);
      chk("first_sym_valid", n, 33);
      chk("clk_m_per_sym", m_cnt - m0, 4);
      chk("clk_level_on", clk_level, 1);
      tick;
      chk("clk_level_pulse", clk_level, 0);
      for (int i = 0; i < 20; i++) begin
         wait_acc(i + 1, 400);
         chk($sformatf("tbl_sym%0d", i), acc_q[i][3:0], tbl[i].sym);
         chk($sformatf("tbl_align%0d", i), acc_q[i][4], tbl[i].align);
      end
      wait_acc(25, 400);
      chk("gap_pre_data", lvl_q[4] - lvl_q[3], 32);
      chk("gap_frame_seam", lvl_q[20] - lvl_q[19], 32);

      // backpressure on the second frame
      wait_acc(26, 400);
      sym_ready = 0;
      k = 0;
      while (!sym_valid && k < 100) begin
         tick;
         k++;
      end
      m0 = m_cnt;
      held = sym_out;
      stable = 1;
      repeat (100) begin
         tick;
         if (sym_out !== held || !sym_valid) stable = 0;
      end
      chk("bp_clk_m", m_cnt - m0, 3);
      chk("bp_stable", stable, 1);
      chk("bp_clk_m_low", clk_m, 0);
      sym_ready = 1;
      #1;
      chk("bp_release_clk_m", clk_m, 1);
      tick;
      chk("bp_one_accept", acc_q.size(), 27);
      chk("bp_next_valid", sym_valid, 1);
      chk("bp_next_level", clk_level, 1);
      wait_acc(40, 800);
      for (int s = 20; s < 40; s++) chk($sformatf("f2_sym%0d", s), acc_q[s], exp_a(s));

      // enable dropped mid third frame
      wait_acc(46, 400);
      enable = 0;
      wait_acc(60, 700);
      for (int s = 40; s < 60; s++) chk($sformatf("f3_sym%0d", s), acc_q[s], exp_a(s));
      chk("end_busy", frame_busy, 0);
      m0 = m_cnt;
      repeat (60) tick;
      chk("end_no_clk_m", m_cnt - m0, 0);
      chk("end_no_sym", acc_q.size(), 60);

      // async reset mid-DATA, then restart
      acc_q.delete();
      enable = 1;
      wait_acc(6, 400);
      repeat (3) tick;
      rst = 0;
      #1;
      chk("async_rst_outs", outs(), 0);
      repeat (2) tick;
      acc_q.delete();
      rst = 1;
      wait_acc(6, 400);
      chk("rst_pre0", acc_q[0], {1'b0, 4'h3});
      chk("rst_pre1", acc_q[1], {1'b0, 4'hC});
      chk("rst_data0", acc_q[4], {1'b1, 4'hB});
      chk("rst_data1", acc_q[5], {1'b0, 4'h5});
      chk("rst_underrun", underrun_cnt, 0);

      // underrun: two empty slots, then saturation
      bit_valid = 0;
      n = 0;
      k = 0;
      while (n < 2 && k < 100) begin
         if (bit_ready) n++;
         tick;
         k++;
      end
      bit_valid = 1;
      #1;
      chk("underrun_2", underrun_cnt, 2);
      wait_acc(8, 200);
      chk("underrun_sym", acc_q[6][3:0], 4'h3);
      chk("after_underrun_sym", acc_q[7][3:0], 4'hB);
      bit_valid = 0;
      n = 0;
      k = 0;
      while (n < 300 && k < 6000) begin
         if (bit_ready) n++;
         tick;
         k++;
      end
      chk("underrun_slots", n, 300);
      chk("underrun_sat", underrun_cnt, 255);
      enable = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
